hdmi_axi_rd_master: RTL and testbench
=====================================

Name: hdmi_axi_rd_master

Overview:
- AXI4 read master sitting directly downstream of the HDMI read-address generator.
- Accepts one read command (kick/read_addr/read_num), holds busy for its whole duration, splits it into AXI4 INCR bursts and streams returned R data into the pixel FIFO.
- Data-side flow control comes from the FIFO's almost-full flag.

Parameters:
- DATA_WIDTH, 32, AXI R data width in bits (one word = one pixel); 32/64/128 only.
- BURST_MAX, 64, maximum beats per AR burst (1..256).
- MAX_OUTST, 4, maximum AR bursts issued but not fully received (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- kick  in  1  command request; sampled only in IDLE
- read_addr  in  32  byte start address; DATA_WIDTH/8 aligned
- read_num  in  32  beat count; bits [15:0] used, [31:16] ignored
- busy  out  1  command in progress
- m_axi_araddr  out  32  burst address
- m_axi_arlen  out  8  beats-1
- m_axi_arsize  out  3  log2(DATA_WIDTH/8), constant
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arcache  out  4  constant 4'b0011
- m_axi_arprot  out  3  constant 0
- m_axi_arid  out  4  constant 0
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- fifo_din  out  DATA_WIDTH  pixel data to FIFO
- fifo_wr_en  out  1  FIFO write strobe
- fifo_afull  in  1  FIFO almost full (at least 2 free slots remain when asserted)

Behaviour:
- Reset values: busy=0, m_axi_arvalid=0, m_axi_rready=0, fifo_wr_en=0, m_axi_araddr=0, m_axi_arlen=0, all counters 0, state=IDLE.
- Reset may assert mid-command; it aborts immediately, and outstanding AXI beats after reset are the interconnect's concern.
- States:
  - IDLE: if kick=1, latch the address and num[15:0], go to RUN. busy=1 from the next cycle.
  - RUN: issue AR bursts and receive R beats. When the received-beat count equals num, go to DONE.
  - DONE: busy=1 for this one cycle, then IDLE with busy=0.
  - kick is ignored outside IDLE, so a kick held while busy=1 is never re-accepted.
- num=0: IDLE -> DONE directly. busy is high for exactly one cycle and no AXI traffic occurs.
- AR generation, in RUN:
  - Allowed when remaining AR beats > 0 and outstanding < MAX_OUTST.
  - len_beats = min(remaining AR beats, BURST_MAX, beats to next 4 KB boundary).
  - Beats to boundary = (4096 - addr[11:0]) / (DATA_WIDTH/8).
  - arlen = len_beats-1. arvalid and all AR fields stay stable until arready.
  - On handshake: addr += len_beats*(DATA_WIDTH/8), remaining AR -= len_beats, outstanding += 1.
  - arvalid may be reasserted the cycle after a handshake.
- R path:
  - m_axi_rready = (state==RUN) & ~fifo_afull (registered).
  - On each rvalid&rready: fifo_din<=rdata and fifo_wr_en=1 the following cycle (1-cycle latency), received count += 1.
  - On rlast handshake: outstanding -= 1.
  - An AR handshake and an rlast in the same cycle leave outstanding unchanged.
- Arithmetic: 32-bit address wraps modulo 2^32; no bursts ever cross 4 KB.
- RRESP is ignored unless the optional feature below is enabled; data is always written.

Optional Feature:
- Macro HDMI_RD_RRESP_CHECK_EN.
- When defined: adds output rd_err (1 bit, reset 0). It is sticky-set when any beat has rresp != 2'b00. It is cleared only on the cycle a new kick is accepted in IDLE. Data is still forwarded.
- When undefined: no rd_err port and no related logic.

Decomposition:
- Package hdmi_rd_pkg holds:
  - state encoding (IDLE/RUN/DONE)
  - AXI constants (ARBURST_INCR, ARCACHE_DEF, RESP_OKAY)
  - the 4 KB boundary size
  - a function computing arsize from DATA_WIDTH
- One sub-module, hdmi_axi_ar_split: computes the burst length from the address, the remaining count, BURST_MAX and the 4 KB boundary, and drives the AR channel with the outstanding counter. The top level holds the FSM and the R path.

Test Plan:
- kick with addr=0x0, num=256, arready/rvalid always 1, afull=0 -> 4 ARs with arlen=63 at addresses 0x000, 0x100, 0x200, 0x300; 256 fifo_wr_en pulses; busy falls 1 cycle after the DONE cycle.
- addr=0xF80, num=64 -> ARs at 0xF80 with arlen=31 and at 0x1000 with arlen=31; no 4 KB crossing.
- arready held low -> at most MAX_OUTST=4 bursts accepted before any rlast; a 5th arvalid waits until the first rlast.
- fifo_afull toggled every 8 cycles during num=128 -> rready low within 1 cycle of afull; no beat lost; exactly 128 writes in address order.
- num=0 kick -> busy high for exactly 1 cycle; arvalid never asserted.
- rst_n pulled low mid-burst -> busy, arvalid, rready and fifo_wr_en all 0 asynchronously; a new kick after release starts cleanly. With HDMI_RD_RRESP_CHECK_EN, one SLVERR beat sets rd_err, which is cleared on the next kick.

Source files
------------

// File: rtl/hdmi_axi_rd_master_pkg.sv
// Shared definitions for the HDMI AXI4 read master: FSM states, AXI constants
// and the AxSIZE helper.
package hdmi_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } rd_state_e;

    localparam logic [1:0]  ARBURST_INCR   = 2'b01;
    localparam logic [3:0]  ARCACHE_DEF    = 4'b0011;
    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam int unsigned BOUNDARY_BYTES = 4096;

    function automatic logic [2:0] arsize_f(input int unsigned data_width);
        case (data_width)
            64:      return 3'd3;
            128:     return 3'd4;
            default: return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_axi_rd_master_if.sv
// AXI4 read-channel bundle (AR + R) between the HDMI read master and the interconnect.
interface hdmi_axi_rd_master_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [31:0]           m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic [3:0]            m_axi_arid;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arcache, m_axi_arprot, m_axi_arid, m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arcache, m_axi_arprot, m_axi_arid, m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

endinterface

// File: rtl/hdmi_axi_rd_master_ar_split.sv
// AR channel generator: splits a command into INCR bursts bounded by BURST_MAX
// and the 4 KB boundary, and limits bursts in flight to MAX_OUTST.
module hdmi_axi_ar_split
    import hdmi_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_MAX  = 64,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        run_i,
    input  logic [31:0] addr_i,
    input  logic [15:0] num_i,
    input  logic        rlast_hs_i,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    output logic [7:0]  arlen_o,
    output logic        arvalid_o
);

    localparam logic [2:0]  SZ   = arsize_f(DATA_WIDTH);
    localparam logic [16:0] BMAX = 17'(BURST_MAX);
    localparam logic [3:0]  OMAX = 4'(MAX_OUTST);

    logic [31:0] addr_q;
    logic [15:0] rem_q;
    logic [3:0]  outst_q;
    logic [7:0]  arlen_q;
    logic [8:0]  len_q;
    logic        arvalid_q;

    logic [12:0] bnd_bytes;
    logic [16:0] bnd_beats;
    logic [16:0] len_c;
    logic        can_issue;
    logic        ar_hs;

    always_comb begin
        bnd_bytes = 13'(BOUNDARY_BYTES) - {1'b0, addr_q[11:0]};
        bnd_beats = {4'b0, bnd_bytes >> SZ};
        len_c     = {1'b0, rem_q};
        if (len_c > BMAX)      len_c = BMAX;
        if (len_c > bnd_beats) len_c = bnd_beats;
        can_issue = run_i && !arvalid_q && (rem_q != '0) && (outst_q < OMAX);
        ar_hs     = arvalid_q && arready_i;
    end

    // addr_q/arlen_q only move on handshake or load, so AR fields hold while arvalid waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            rem_q     <= '0;
            outst_q   <= '0;
            arlen_q   <= '0;
            len_q     <= '0;
            arvalid_q <= 1'b0;
        end else if (start_i) begin
            addr_q    <= addr_i;
            rem_q     <= num_i;
            outst_q   <= '0;
            arvalid_q <= 1'b0;
        end else begin
            if (can_issue) begin
                arvalid_q <= 1'b1;
                arlen_q   <= 8'(len_c - 17'd1);
                len_q     <= 9'(len_c);
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
                addr_q    <= addr_q + ({23'b0, len_q} << SZ);
                rem_q     <= rem_q - {7'b0, len_q};
            end
            case ({ar_hs, rlast_hs_i})
                2'b10:   outst_q <= outst_q + 4'd1;
                2'b01:   outst_q <= outst_q - 4'd1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    assign araddr_o  = addr_q;
    assign arlen_o   = arlen_q;
    assign arvalid_o = arvalid_q;

endmodule

// File: rtl/hdmi_axi_rd_master.sv
// HDMI AXI4 read master: command FSM and R path into the pixel FIFO.
// Optional HDMI_RD_RRESP_CHECK_EN adds a sticky rd_err output for non-OKAY responses.
module hdmi_axi_rd_master
    import hdmi_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_MAX  = 64,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  kick,
    input  logic [31:0]           read_addr,
    input  logic [31:0]           read_num,
    output logic                  busy,
    hdmi_axi_rd_master_if.master  axi,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_wr_en,
    input  logic                  fifo_afull
`ifdef HDMI_RD_RRESP_CHECK_EN
    ,
    output logic                  rd_err
`endif
);

    rd_state_e             state_q;
    logic [15:0]           num_q;
    logic [15:0]           rx_cnt_q;
    logic                  busy_q;
    logic                  rready_q;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] din_q;

    logic r_hs;
    logic start;
    logic unused_num_hi;

    assign r_hs          = axi.m_axi_rvalid && rready_q;
    assign start         = (state_q == ST_IDLE) && kick;
    assign unused_num_hi = ^read_num[31:16];

    hdmi_axi_ar_split #(
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_MAX  (BURST_MAX),
        .MAX_OUTST  (MAX_OUTST)
    ) u_ar_split (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .run_i      (state_q == ST_RUN),
        .addr_i     (read_addr),
        .num_i      (read_num[15:0]),
        .rlast_hs_i (r_hs && axi.m_axi_rlast),
        .arready_i  (axi.m_axi_arready),
        .araddr_o   (axi.m_axi_araddr),
        .arlen_o    (axi.m_axi_arlen),
        .arvalid_o  (axi.m_axi_arvalid)
    );

    // Leaving RUN on the final beat's handshake lets DONE follow immediately and drops rready at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            num_q    <= '0;
            rx_cnt_q <= '0;
            busy_q   <= 1'b0;
            rready_q <= 1'b0;
            wr_en_q  <= 1'b0;
            din_q    <= '0;
        end else begin
            wr_en_q <= r_hs;
            if (r_hs) din_q <= axi.m_axi_rdata;
            case (state_q)
                ST_IDLE: begin
                    rready_q <= 1'b0;
                    if (kick) begin
                        num_q    <= read_num[15:0];
                        rx_cnt_q <= '0;
                        busy_q   <= 1'b1;
                        if (read_num[15:0] == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q  <= ST_RUN;
                            rready_q <= !fifo_afull;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_hs) rx_cnt_q <= rx_cnt_q + 16'd1;
                    if (r_hs && (rx_cnt_q + 16'd1 == num_q)) begin
                        state_q  <= ST_DONE;
                        rready_q <= 1'b0;
                    end else begin
                        rready_q <= !fifo_afull;
                    end
                end
                ST_DONE: begin
                    busy_q   <= 1'b0;
                    rready_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef HDMI_RD_RRESP_CHECK_EN
    logic rd_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err_q <= 1'b0;
        end else if (start) begin
            rd_err_q <= 1'b0;
        end else if (r_hs && (axi.m_axi_rresp != RESP_OKAY)) begin
            rd_err_q <= 1'b1;
        end
    end

    assign rd_err = rd_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^axi.m_axi_rresp;
`endif

    assign axi.m_axi_arsize  = arsize_f(DATA_WIDTH);
    assign axi.m_axi_arburst = ARBURST_INCR;
    assign axi.m_axi_arcache = ARCACHE_DEF;
    assign axi.m_axi_arprot  = '0;
    assign axi.m_axi_arid    = '0;
    assign axi.m_axi_rready  = rready_q;

    assign busy       = busy_q;
    assign fifo_din   = din_q;
    assign fifo_wr_en = wr_en_q;

endmodule

// File: tb/tb_hdmi_axi_rd_master.sv
// Directed self-checking bench for hdmi_axi_rd_master with a behavioural AXI read slave.
module tb_hdmi_axi_rd_master;
    import hdmi_rd_pkg::*;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          kick = 1'b0;
    logic [31:0]   read_addr = '0;
    logic [31:0]   read_num = '0;
    logic          busy;
    logic [DW-1:0] fifo_din;
    logic          fifo_wr_en;
    logic          fifo_afull = 1'b0;
`ifdef HDMI_RD_RRESP_CHECK_EN
    logic          rd_err;
`endif

    hdmi_axi_rd_master_if #(.DATA_WIDTH(DW)) axi ();

    hdmi_axi_rd_master #(
        .DATA_WIDTH (DW),
        .BURST_MAX  (64),
        .MAX_OUTST  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kick       (kick),
        .read_addr  (read_addr),
        .read_num   (read_num),
        .busy       (busy),
        .axi        (axi),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_afull (fifo_afull)
`ifdef HDMI_RD_RRESP_CHECK_EN
        ,
        .rd_err     (rd_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned len;
    } burst_t;

    burst_t      rq[$];
    logic [31:0] ar_addr_log[$];
    int unsigned ar_len_log[$];
    logic [31:0] wr_log[$];
    int unsigned beat = 0;
    int          beat_total = 0;
    int          err_beat = -1;
    int unsigned outst = 0;
    int unsigned max_outst = 0;
    int unsigned afull_viol = 0;
    int unsigned arvalid_seen = 0;
    logic        afull_prev = 1'b0;
    bit          ar_rdy = 1'b1;
    bit          r_en = 1'b1;

    int unsigned checks = 0;
    int unsigned passed = 0;

    // Monitor: values seen at negedge are those the next posedge will sample.
    always @(negedge clk) begin
        if (!rst_n) begin
            rq.delete();
            beat  = 0;
            outst = 0;
        end else begin
            if (axi.m_axi_arvalid) arvalid_seen++;
            if (axi.m_axi_arvalid && axi.m_axi_arready) begin
                rq.push_back('{addr: axi.m_axi_araddr, len: int'(axi.m_axi_arlen)});
                ar_addr_log.push_back(axi.m_axi_araddr);
                ar_len_log.push_back(int'(axi.m_axi_arlen));
                outst++;
                if (outst > max_outst) max_outst = outst;
            end
            if (axi.m_axi_rvalid && axi.m_axi_rready) begin
                beat_total++;
                if (axi.m_axi_rlast) begin
                    rq.delete(0);
                    beat = 0;
                    outst--;
                end else begin
                    beat++;
                end
            end
            if (fifo_wr_en) wr_log.push_back(fifo_din);
            if (afull_prev && axi.m_axi_rready) afull_viol++;
        end
        afull_prev = fifo_afull;
    end

    // Slave driver: rdata is the byte address of the beat.
    always @(posedge clk) begin
        #1;
        axi.m_axi_arready = ar_rdy;
        if (rst_n && r_en && rq.size() != 0) begin
            axi.m_axi_rvalid = 1'b1;
            axi.m_axi_rdata  = rq[0].addr + 32'(beat * 4);
            axi.m_axi_rlast  = (beat == rq[0].len);
            axi.m_axi_rresp  = (beat_total == err_beat) ? 2'b10 : 2'b00;
        end else begin
            axi.m_axi_rvalid = 1'b0;
            axi.m_axi_rdata  = '0;
            axi.m_axi_rlast  = 1'b0;
            axi.m_axi_rresp  = 2'b00;
        end
    end

    task automatic kick_cmd(input logic [31:0] a, input logic [31:0] n);
        ar_addr_log.delete();
        ar_len_log.delete();
        wr_log.delete();
        arvalid_seen = 0;
        afull_viol   = 0;
        max_outst    = 0;
        @(posedge clk); #1;
        read_addr = a;
        read_num  = n;
        kick      = 1'b1;
        @(posedge clk); #1;
        kick = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget, output bit ok);
        int unsigned n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (axi.m_axi_arvalid !== 1'b0) $display("FAIL reset_arvalid got=%b exp=0", axi.m_axi_arvalid); else passed++;
        checks++; if (axi.m_axi_rready !== 1'b0) $display("FAIL reset_rready got=%b exp=0", axi.m_axi_rready); else passed++;
        checks++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); else passed++;
        checks++; if (axi.m_axi_araddr !== 32'h0) $display("FAIL reset_araddr got=%h exp=0", axi.m_axi_araddr); else passed++;
        checks++; if (axi.m_axi_arlen !== 8'h0) $display("FAIL reset_arlen got=%h exp=0", axi.m_axi_arlen); else passed++;
`ifdef HDMI_RD_RRESP_CHECK_EN
        checks++; if (rd_err !== 1'b0) $display("FAIL reset_rd_err got=%b exp=0", rd_err); else passed++;
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int unsigned n_wr = 0, cyc = 0, bad = 0;
        bit got = 0;
        logic busy_last = 1'b0, busy_after = 1'b1;
        kick_cmd(32'h0, 32'd256);
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy_start got=%b exp=1", busy); else passed++;
        while (cyc < 3000 && !got) begin
            if (fifo_wr_en) begin
                n_wr++;
                if (n_wr == 256) begin
                    busy_last = busy;
                    @(posedge clk); #1;
                    busy_after = busy;
                    got = 1;
                end
            end
            if (!got) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checks++; if (got !== 1'b1) $display("FAIL basic_timeout writes=%0d exp=256", n_wr); else passed++;
        checks++; if (busy_last !== 1'b1) $display("FAIL basic_busy_done got=%b exp=1", busy_last); else passed++;
        checks++; if (busy_after !== 1'b0) $display("FAIL basic_busy_fall got=%b exp=0", busy_after); else passed++;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (ar_addr_log.size() !== 4) $display("FAIL basic_ar_count got=%0d exp=4", ar_addr_log.size()); else passed++;
        foreach (ar_addr_log[i])
            if (ar_addr_log[i] !== 32'(i * 256) || ar_len_log[i] != 63) bad++;
        checks++; if (bad !== 0) $display("FAIL basic_ar_fields bad=%0d exp=0", bad); else passed++;
        checks++; if (wr_log.size() !== 256) $display("FAIL basic_wr_count got=%0d exp=256", wr_log.size()); else passed++;
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i] !== 32'(i * 4)) bad++;
        checks++; if (bad !== 0) $display("FAIL basic_wr_order bad=%0d exp=0", bad); else passed++;
        checks++;
        if ({axi.m_axi_arsize, axi.m_axi_arburst, axi.m_axi_arcache} !== {3'd2, 2'b01, 4'b0011})
            $display("FAIL basic_ar_const got=%b exp=%b", {axi.m_axi_arsize, axi.m_axi_arburst, axi.m_axi_arcache}, {3'd2, 2'b01, 4'b0011});
        else passed++;
        checks++;
        if ({axi.m_axi_arprot, axi.m_axi_arid} !== 7'b0)
            $display("FAIL basic_prot_id got=%b exp=0", {axi.m_axi_arprot, axi.m_axi_arid});
        else passed++;
    endtask

    task automatic test_4k();
        bit ok;
        int unsigned bad = 0;
        kick_cmd(32'h0000_0F80, 32'd64);
        wait_idle(2000, ok);
        checks++; if (ok !== 1'b1) $display("FAIL k4_timeout busy=%b exp=0", busy); else passed++;
        checks++; if (ar_addr_log.size() !== 2) $display("FAIL k4_ar_count got=%0d exp=2", ar_addr_log.size()); else passed++;
        if (ar_addr_log.size() == 2) begin
            checks++;
            if (ar_addr_log[0] !== 32'h0F80 || ar_len_log[0] != 31 || ar_addr_log[1] !== 32'h1000 || ar_len_log[1] != 31)
                $display("FAIL k4_ar_fields got=%h/%0d %h/%0d exp=00000f80/31 00001000/31",
                         ar_addr_log[0], ar_len_log[0], ar_addr_log[1], ar_len_log[1]);
            else passed++;
        end
        foreach (wr_log[i]) if (wr_log[i] !== 32'h0F80 + 32'(i * 4)) bad++;
        checks++; if (wr_log.size() !== 64 || bad !== 0) $display("FAIL k4_wr count=%0d bad=%0d exp=64/0", wr_log.size(), bad); else passed++;
    endtask

    task automatic test_outst();
        bit ok;
        int unsigned bad = 0;
        r_en   = 1'b0;
        ar_rdy = 1'b0;
        kick_cmd(32'h0001_0000, 32'd384);
        repeat (6) @(posedge clk);
        #1;
        checks++; if (axi.m_axi_arvalid !== 1'b1) $display("FAIL outst_arvalid_hold got=%b exp=1", axi.m_axi_arvalid); else passed++;
        checks++;
        if (axi.m_axi_araddr !== 32'h0001_0000 || axi.m_axi_arlen !== 8'd63)
            $display("FAIL outst_ar_stable got=%h/%0d exp=00010000/63", axi.m_axi_araddr, axi.m_axi_arlen);
        else passed++;
        ar_rdy = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (ar_addr_log.size() !== 4) $display("FAIL outst_limit got=%0d exp=4", ar_addr_log.size()); else passed++;
        r_en = 1'b1;
        wait_idle(3000, ok);
        checks++; if (ok !== 1'b1) $display("FAIL outst_timeout busy=%b exp=0", busy); else passed++;
        checks++; if (ar_addr_log.size() !== 6) $display("FAIL outst_ar_total got=%0d exp=6", ar_addr_log.size()); else passed++;
        checks++; if (max_outst !== 4) $display("FAIL outst_max got=%0d exp=4", max_outst); else passed++;
        foreach (wr_log[i]) if (wr_log[i] !== 32'h0001_0000 + 32'(i * 4)) bad++;
        checks++; if (wr_log.size() !== 384 || bad !== 0) $display("FAIL outst_wr count=%0d bad=%0d exp=384/0", wr_log.size(), bad); else passed++;
    endtask

    task automatic test_afull();
        int unsigned cyc = 0, bad = 0;
        kick_cmd(32'h0002_0000, 32'd128);
        while (busy && cyc < 3000) begin
            if (cyc % 8 == 0) fifo_afull = ~fifo_afull;
            @(posedge clk); #1;
            cyc++;
        end
        fifo_afull = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL afull_timeout busy=%b exp=0", busy); else passed++;
        checks++; if (afull_viol !== 0) $display("FAIL afull_rready violations=%0d exp=0", afull_viol); else passed++;
        foreach (wr_log[i]) if (wr_log[i] !== 32'h0002_0000 + 32'(i * 4)) bad++;
        checks++; if (wr_log.size() !== 128) $display("FAIL afull_wr_count got=%0d exp=128", wr_log.size()); else passed++;
        checks++; if (bad !== 0) $display("FAIL afull_wr_order bad=%0d exp=0", bad); else passed++;
    endtask

    task automatic test_zero();
        int unsigned n_busy;
        kick_cmd(32'h0000_0040, 32'd0);
        n_busy = busy ? 1 : 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busy) n_busy++;
        end
        checks++; if (n_busy !== 1) $display("FAIL zero_busy_cycles got=%0d exp=1", n_busy); else passed++;
        checks++; if (arvalid_seen !== 0) $display("FAIL zero_arvalid got=%0d exp=0", arvalid_seen); else passed++;
        checks++; if (wr_log.size() !== 0) $display("FAIL zero_writes got=%0d exp=0", wr_log.size()); else passed++;
        // Upper bits of read_num are ignored, so this is also an empty command.
        kick_cmd(32'h0000_0080, 32'h0001_0000);
        n_busy = busy ? 1 : 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busy) n_busy++;
        end
        checks++; if (n_busy !== 1) $display("FAIL zero_hi_busy_cycles got=%0d exp=1", n_busy); else passed++;
        checks++; if (arvalid_seen !== 0) $display("FAIL zero_hi_arvalid got=%0d exp=0", arvalid_seen); else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int unsigned bad = 0;
        kick_cmd(32'h0, 32'd256);
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, axi.m_axi_arvalid, axi.m_axi_rready, fifo_wr_en} !== 4'b0)
            $display("FAIL rstmid_async got=%b exp=0000", {busy, axi.m_axi_arvalid, axi.m_axi_rready, fifo_wr_en});
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        kick_cmd(32'h0000_3000, 32'd32);
        wait_idle(1000, ok);
        checks++; if (ok !== 1'b1) $display("FAIL rstmid_timeout busy=%b exp=0", busy); else passed++;
        checks++; if (ar_addr_log.size() !== 1) $display("FAIL rstmid_ar_count got=%0d exp=1", ar_addr_log.size()); else passed++;
        if (ar_addr_log.size() == 1) begin
            checks++;
            if (ar_addr_log[0] !== 32'h3000 || ar_len_log[0] != 31)
                $display("FAIL rstmid_ar_fields got=%h/%0d exp=00003000/31", ar_addr_log[0], ar_len_log[0]);
            else passed++;
        end
        foreach (wr_log[i]) if (wr_log[i] !== 32'h3000 + 32'(i * 4)) bad++;
        checks++; if (wr_log.size() !== 32 || bad !== 0) $display("FAIL rstmid_wr count=%0d bad=%0d exp=32/0", wr_log.size(), bad); else passed++;
    endtask

`ifdef HDMI_RD_RRESP_CHECK_EN
    task automatic test_rresp();
        bit ok;
        err_beat = beat_total + 5;
        kick_cmd(32'h0000_5000, 32'd16);
        wait_idle(1000, ok);
        err_beat = -1;
        checks++; if (ok !== 1'b1) $display("FAIL rresp_timeout busy=%b exp=0", busy); else passed++;
        checks++; if (rd_err !== 1'b1) $display("FAIL rresp_set got=%b exp=1", rd_err); else passed++;
        checks++; if (wr_log.size() !== 16) $display("FAIL rresp_wr_count got=%0d exp=16", wr_log.size()); else passed++;
        kick_cmd(32'h0000_6000, 32'd4);
        checks++; if (rd_err !== 1'b0) $display("FAIL rresp_clear got=%b exp=0", rd_err); else passed++;
        wait_idle(1000, ok);
        checks++; if (rd_err !== 1'b0) $display("FAIL rresp_stay_clear got=%b exp=0", rd_err); else passed++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_4k();
        test_outst();
        test_afull();
        test_zero();
        test_reset_mid();
`ifdef HDMI_RD_RRESP_CHECK_EN
        test_rresp();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
